// File: rtl/float_discriminant_collector.sv
// Result collector downstream of the float discriminant distributor: captures every result
// into an in-order FIFO and presents a show-ahead head entry with throttle and sticky stats.
module float_discriminant_collector #(
    parameter int unsigned FLEN         = 64,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_MARGIN = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [FLEN-1:0]          in_res,
    input  logic                     in_negative,
    input  logic                     in_err,
    output logic                     out_vld,
    input  logic                     out_ready,
    output logic [FLEN-1:0]          out_res,
    output logic                     out_negative,
    output logic                     out_err,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              err_count,
    input  logic                     clr_stats
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = FLEN + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] head_q, head_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   err_count_q, err_count_d;
    logic          push, pop;

    always_comb begin
        pop  = (level_q != '0) && out_ready;
        push = in_vld && ((level_q != LW'(DEPTH)) || pop);

        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end

        // The head register preloads the entry at the next rptr; when that slot is being
        // written this cycle (sole entry after the edge) the incoming word is forwarded.
        head_d = head_q;
        if (push && (level_d == LW'(1))) begin
            head_d = {in_res, in_negative, in_err};
        end else if (level_d != '0) begin
            head_d = mem_q[rptr_d];
        end

        overflow_d = overflow_q;
        if (clr_stats) begin
            overflow_d = 1'b0;
        end else if (in_vld && !push) begin
            overflow_d = 1'b1;
        end

        err_count_d = err_count_q;
        if (clr_stats) begin
            err_count_d = '0;
        end else if (push && in_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_res, in_negative, in_err};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_vld                           = (level_q != '0);
    assign {out_res, out_negative, out_err}  = head_q;
    assign level                             = level_q;
    assign almost_full                       = (LW'(DEPTH) - level_q) <= LW'(AFULL_MARGIN);
    assign overflow                          = overflow_q;
    assign err_count                         = err_count_q;

endmodule

// File: tb/tb_float_discriminant_collector.sv
// Directed bench for float_discriminant_collector: ordering, fill/overflow, full-rate
// wrap, throttled random drain, asynchronous reset and error statistics saturation.
module tb_float_discriminant_collector;

    localparam int unsigned FLEN  = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFM   = 10;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_vld = 1'b0;
    logic [FLEN-1:0] in_res = '0;
    logic            in_negative = 1'b0;
    logic            in_err = 1'b0;
    logic            out_vld;
    logic            out_ready = 1'b0;
    logic [FLEN-1:0] out_res;
    logic            out_negative;
    logic            out_err;
    logic            almost_full;
    logic [LW-1:0]   level;
    logic            overflow;
    logic [15:0]     err_count;
    logic            clr_stats = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [FLEN+1:0] q[$];

    float_discriminant_collector #(
        .FLEN(FLEN),
        .DEPTH(DEPTH),
        .AFULL_MARGIN(AFM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_vld(in_vld),
        .in_res(in_res),
        .in_negative(in_negative),
        .in_err(in_err),
        .out_vld(out_vld),
        .out_ready(out_ready),
        .out_res(out_res),
        .out_negative(out_negative),
        .out_err(out_err),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow),
        .err_count(err_count),
        .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
        vectors++; if (level !== '0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL reset_err_count got %h exp 0", err_count); end
        vectors++; if ({out_res, out_negative, out_err} !== '0) begin miscompares++; $display("FAIL reset_out_data got %h/%b/%b exp 0", out_res, out_negative, out_err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_in_order();
        out_ready = 1'b1;
        in_vld = 1'b1; in_res = 64'h3FF0_0000_0000_0000; in_negative = 1'b0; in_err = 1'b0;
        step();
        vectors++; if (out_vld !== 1'b1) begin miscompares++; $display("FAIL order_vld1 got %b exp 1", out_vld); end
        vectors++; if ({out_res, out_negative, out_err} !== {64'h3FF0_0000_0000_0000, 2'b00}) begin miscompares++; $display("FAIL order_e1 got %h/%b/%b exp 3ff0000000000000/0/0", out_res, out_negative, out_err); end
        in_res = 64'hC010_0000_0000_0000; in_negative = 1'b1; in_err = 1'b0;
        step();
        vectors++; if ({out_res, out_negative, out_err} !== {64'hC010_0000_0000_0000, 2'b10}) begin miscompares++; $display("FAIL order_e2 got %h/%b/%b exp c010000000000000/1/0", out_res, out_negative, out_err); end
        vectors++; if (level !== LW'(1)) begin miscompares++; $display("FAIL order_level2 got %0d exp 1", level); end
        in_res = 64'h7FF8_0000_0000_0000; in_negative = 1'b0; in_err = 1'b1;
        step();
        vectors++; if ({out_res, out_negative, out_err} !== {64'h7FF8_0000_0000_0000, 2'b01}) begin miscompares++; $display("FAIL order_e3 got %h/%b/%b exp 7ff8000000000000/0/1", out_res, out_negative, out_err); end
        in_vld = 1'b0; in_err = 1'b0;
        step();
        vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL order_drained got %b exp 0", out_vld); end
        vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL order_err_count got %0d exp 1", err_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [63:0] base;
        base = 64'h4000_0000_0000_0000;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_vld = 1'b1; in_res = base + 64'(i); in_negative = 1'b0; in_err = 1'b0;
            step();
            vectors++; if (level !== LW'(i + 1)) begin miscompares++; $display("FAIL fill_level got %0d exp %0d", level, i + 1); end
            vectors++; if (almost_full !== (i + 1 >= 6)) begin miscompares++; $display("FAIL fill_afull at level %0d got %b exp %b", i + 1, almost_full, (i + 1 >= 6)); end
        end
        in_res = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_overflow got %b exp 1", overflow); end
        vectors++; if (level !== LW'(16)) begin miscompares++; $display("FAIL drop_level got %0d exp 16", level); end
        vectors++; if (out_res !== base) begin miscompares++; $display("FAIL drop_head_stable got %h exp %h", out_res, base); end
        in_vld = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++; if (out_vld !== 1'b1 || out_res !== base + 64'(i)) begin miscompares++; $display("FAIL drain_%0d got %b/%h exp 1/%h", i, out_vld, out_res, base + 64'(i)); end
            step();
        end
        vectors++; if (out_vld !== 1'b0 || level !== '0) begin miscompares++; $display("FAIL drain_empty got vld %b level %0d exp 0/0", out_vld, level); end
        out_ready = 1'b0; clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [FLEN+1:0] e;
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = {64'h5000_0000_0000_0000 + 64'(i), 1'b0, 1'b0};
            in_vld = 1'b1; {in_res, in_negative, in_err} = e; q.push_back(e);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 48; k++) begin
            e = {64'h6000_0000_0000_0000 + 64'(k), k[0], 1'b0};
            {in_res, in_negative, in_err} = e;
            vectors++; if (out_vld !== 1'b1 || {out_res, out_negative, out_err} !== q[0]) begin miscompares++; $display("FAIL wrap_head_%0d got %b/%h exp 1/%h", k, out_vld, {out_res, out_negative, out_err}, q[0]); end
            void'(q.pop_front()); q.push_back(e);
            step();
            vectors++; if (level !== LW'(16) || overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_state_%0d got level %0d ovf %b exp 16/0", k, level, overflow); end
        end
        in_vld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vectors++; if (out_vld !== 1'b1 || {out_res, out_negative, out_err} !== q[0]) begin miscompares++; $display("FAIL wrap_drain_%0d got %b/%h exp 1/%h", i, out_vld, {out_res, out_negative, out_err}, q[0]); end
            void'(q.pop_front());
            step();
        end
        vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b exp 0", out_vld); end
        out_ready = 1'b0;
    endtask

    task automatic test_random_throttled();
        logic [FLEN+1:0] pdata[10];
        logic            pv[10];
        logic            issue;
        int              sent, received, cyc;
        sent = 0; received = 0; cyc = 0;
        q.delete();
        for (int j = 0; j < 10; j++) begin pv[j] = 1'b0; pdata[j] = '0; end
        while (received < 200 && cyc < 5000) begin
            in_vld = pv[9]; {in_res, in_negative, in_err} = pdata[9];
            out_ready = 1'($urandom_range(0, 1));
            issue = (sent < 200) && !almost_full;
            if (out_vld !== (q.size() != 0)) begin
                vectors++; miscompares++;
                $display("FAIL rand_vld got %b exp %b", out_vld, q.size() != 0);
            end else if (out_vld && out_ready) begin
                vectors++; if ({out_res, out_negative, out_err} !== q[0]) begin miscompares++; $display("FAIL rand_data_%0d got %h exp %h", received, {out_res, out_negative, out_err}, q[0]); end
                void'(q.pop_front());
                received++;
            end
            if (in_vld) q.push_back(pdata[9]);
            step();
            for (int j = 9; j > 0; j--) begin pv[j] = pv[j-1]; pdata[j] = pdata[j-1]; end
            pv[0] = issue;
            pdata[0] = {$urandom, $urandom, 2'($urandom_range(0, 3))};
            if (issue) sent++;
            cyc++;
        end
        in_vld = 1'b0; out_ready = 1'b0;
        vectors++; if (received != 200) begin miscompares++; $display("FAIL rand_timeout got %0d entries exp 200", received); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rand_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_vld = 1'b0; clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_vld = 1'b1; in_res = 64'h7000_0000_0000_0000 + 64'(i); in_negative = 1'b0; in_err = 1'b1;
            step();
        end
        in_vld = 1'b0; in_err = 1'b0;
        vectors++; if (level !== LW'(7) || err_count !== 16'd7) begin miscompares++; $display("FAIL pre_reset got level %0d err %0d exp 7/7", level, err_count); end
        #3 rst = 1'b0;
        #1;
        vectors++; if (out_vld !== 1'b0 || level !== '0 || err_count !== 16'd0) begin miscompares++; $display("FAIL async_reset got vld %b level %0d err %0d exp 0/0/0", out_vld, level, err_count); end
        vectors++; if (out_res !== '0 || almost_full !== 1'b0) begin miscompares++; $display("FAIL async_reset_out got %h af %b exp 0/0", out_res, almost_full); end
        @(negedge clk);
        #2 rst = 1'b1;
        in_vld = 1'b1; in_res = 64'h1234_5678_9ABC_DEF0;
        step();
        in_vld = 1'b0;
        vectors++; if (out_vld !== 1'b1 || out_res !== 64'h1234_5678_9ABC_DEF0 || level !== LW'(1)) begin miscompares++; $display("FAIL post_reset got %b/%h/%0d exp 1/123456789abcdef0/1", out_vld, out_res, level); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL post_reset_drain got %b exp 0", out_vld); end
    endtask

    task automatic test_err_saturation();
        in_vld = 1'b1; in_err = 1'b1; in_negative = 1'b0; in_res = 64'h7FF0_0000_0000_0000; out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        vectors++; if (err_count !== 16'hFFFE || level !== LW'(1)) begin miscompares++; $display("FAIL sat_fffe got %h level %0d exp fffe/1", err_count, level); end
        step();
        vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_first got %h exp ffff", err_count); end
        step();
        vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %h exp ffff", err_count); end
        in_vld = 1'b0;
        step();
        out_ready = 1'b0; in_err = 1'b0; in_vld = 1'b1;
        for (int i = 0; i < 16; i++) step();
        in_err = 1'b1;
        step();
        vectors++; if (overflow !== 1'b1 || err_count !== 16'hFFFF || level !== LW'(16)) begin miscompares++; $display("FAIL sat_drop got ovf %b err %h level %0d exp 1/ffff/16", overflow, err_count, level); end
        clr_stats = 1'b1;
        step();
        vectors++; if (overflow !== 1'b0 || err_count !== 16'd0) begin miscompares++; $display("FAIL clr_vs_drop got ovf %b err %h exp 0/0", overflow, err_count); end
        clr_stats = 1'b0;
        step();
        vectors++; if (overflow !== 1'b1 || err_count !== 16'd0) begin miscompares++; $display("FAIL redrop got ovf %b err %h exp 1/0", overflow, err_count); end
        out_ready = 1'b1; clr_stats = 1'b1;
        step();
        vectors++; if (overflow !== 1'b0 || err_count !== 16'd0 || level !== LW'(16)) begin miscompares++; $display("FAIL clr_vs_push got ovf %b err %h level %0d exp 0/0/16", overflow, err_count, level); end
        clr_stats = 1'b0; in_vld = 1'b0; in_err = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_back_to_back();
        test_random_throttled();
        test_async_reset();
        test_err_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
